cmos_sr_ctrl: RTL and testbench

CMOS_SR_CTRL -- requirements
Module: cmos_sr_ctrl

---
 rtl/cmos_sr_ctrl.sv | 160 ++++++++++++++++
 tb/tb_cmos_sr_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/cmos_sr_ctrl.sv
// Clocked model of a cross-coupled NOR SR latch with a saturating set-event counter.
// Define CMOS_SR_SYNC_EN to pass s/r through two-flop synchronizers (otherwise one sampling flop).
module cmos_sr_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s,
  input  logic             r,
  output logic             q,
  output logic             qn,
  output logic             illegal,
  output logic [CNT_W-1:0] set_cnt,
  output logic             cnt_valid,
  input  logic             cnt_ack
);

  typedef enum logic [1:0] {
    HOLD0  = 2'b00,
    HOLD1  = 2'b01,
    FORBID = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic s_i_q;
  logic r_i_q;

`ifdef CMOS_SR_SYNC_EN
  logic s_meta_q;
  logic r_meta_q;

  // Two-flop synchronizers: s and r are asynchronous to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_meta_q <= 1'b0;
      r_meta_q <= 1'b0;
      s_i_q    <= 1'b0;
      r_i_q    <= 1'b0;
    end else begin
      s_meta_q <= s;
      r_meta_q <= r;
      s_i_q    <= s_meta_q;
      r_i_q    <= r_meta_q;
    end
  end
`else
  // Single sampling flop per request input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_i_q <= 1'b0;
      r_i_q <= 1'b0;
    end else begin
      s_i_q <= s;
      r_i_q <= r;
    end
  end
`endif

  state_e           state_q, state_d;
  logic             q_q, q_d;
  logic             qn_q, qn_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] set_cnt_q, set_cnt_d;
  logic             cnt_valid_q, cnt_valid_d;
  logic             rise_s;
  logic             sat_s;

  // Next-state logic; an idle input releases FORBID into HOLD0 like a real NOR latch settling.
  always_comb begin
    state_d = state_q;
    case ({s_i_q, r_i_q})
      2'b11: state_d = FORBID;
      2'b10: state_d = HOLD1;
      2'b01: state_d = HOLD0;
      2'b00: begin
        case (state_q)
          HOLD1:   state_d = HOLD1;
          FORBID:  state_d = HOLD0;
          default: state_d = HOLD0;
        endcase
      end
      default: state_d = HOLD0;
    endcase
  end

  // Output decode from the next state so q/qn/illegal register on the same edge as the state.
  always_comb begin
    q_d       = 1'b0;
    qn_d      = 1'b1;
    illegal_d = 1'b0;
    case (state_d)
      HOLD0: begin
        q_d       = 1'b0;
        qn_d      = 1'b1;
        illegal_d = 1'b0;
      end
      HOLD1: begin
        q_d       = 1'b1;
        qn_d      = 1'b0;
        illegal_d = 1'b0;
      end
      FORBID: begin
        q_d       = 1'b0;
        qn_d      = 1'b0;
        illegal_d = 1'b1;
      end
      default: begin
        q_d       = 1'b0;
        qn_d      = 1'b1;
        illegal_d = 1'b0;
      end
    endcase
  end

  // Counter counts every rise of q, including straight out of FORBID; an increment wins over ack.
  always_comb begin
    set_cnt_d   = set_cnt_q;
    cnt_valid_d = cnt_valid_q;
    rise_s      = (state_d == HOLD1) && (state_q != HOLD1);
    sat_s       = (set_cnt_q == CNT_MAX);
    if (rise_s && !sat_s) begin
      set_cnt_d   = set_cnt_q + CNT_ONE;
      cnt_valid_d = 1'b1;
    end else if (cnt_ack && cnt_valid_q) begin
      set_cnt_d   = set_cnt_q;
      cnt_valid_d = 1'b0;
    end else begin
      set_cnt_d   = set_cnt_q;
      cnt_valid_d = cnt_valid_q;
    end
  end

  // State, output and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HOLD0;
      q_q         <= 1'b0;
      qn_q        <= 1'b1;
      illegal_q   <= 1'b0;
      set_cnt_q   <= {CNT_W{1'b0}};
      cnt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      qn_q        <= qn_d;
      illegal_q   <= illegal_d;
      set_cnt_q   <= set_cnt_d;
      cnt_valid_q <= cnt_valid_d;
    end
  end

  assign q         = q_q;
  assign qn        = qn_q;
  assign illegal   = illegal_q;
  assign set_cnt   = set_cnt_q;
  assign cnt_valid = cnt_valid_q;

endmodule

// File: tb/tb_cmos_sr_ctrl.sv
// Scoreboard bench for cmos_sr_ctrl: a latch-level reference model predicts outputs per edge,
// and a monitor pops and compares them one tick after each rising edge.
module tb_cmos_sr_ctrl;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef CMOS_SR_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 1;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             s = 1'b0;
  logic             r = 1'b0;
  logic             cnt_ack = 1'b0;
  logic             q;
  logic             qn;
  logic             illegal;
  logic [CNT_W-1:0] set_cnt;
  logic             cnt_valid;

  cmos_sr_ctrl #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s         (s),
    .r         (r),
    .q         (q),
    .qn        (qn),
    .illegal   (illegal),
    .set_cnt   (set_cnt),
    .cnt_valid (cnt_valid),
    .cnt_ack   (cnt_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             q;
    logic             qn;
    logic             ill;
    logic [CNT_W-1:0] cnt;
    logic             vld;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: latch level, forbidden flag, event count, pending-valid flag.
  logic m_q;
  logic m_forbid;
  int   m_cnt;
  logic m_vld;
  logic ps[0:1];
  logic pr[0:1];

  task automatic model_reset();
    m_q = 1'b0; m_forbid = 1'b0; m_cnt = 0; m_vld = 1'b0;
    ps[0] = 1'b0; ps[1] = 1'b0; pr[0] = 1'b0; pr[1] = 1'b0;
  endtask

  task automatic model_step(input logic si, input logic ri, input logic ai);
    logic us, ur, old_q;
    exp_t e;
    us = ps[D-1];
    ur = pr[D-1];
    for (int k = D - 1; k > 0; k--) begin
      ps[k] = ps[k-1];
      pr[k] = pr[k-1];
    end
    ps[0] = si;
    pr[0] = ri;
    old_q = m_q;
    if (us && ur) begin m_forbid = 1'b1; m_q = 1'b0; end
    else if (us)  begin m_forbid = 1'b0; m_q = 1'b1; end
    else if (ur)  begin m_forbid = 1'b0; m_q = 1'b0; end
    else if (m_forbid) begin m_forbid = 1'b0; m_q = 1'b0; end
    if (m_q && !old_q && m_cnt < CNT_MAX) begin
      m_cnt = m_cnt + 1;
      m_vld = 1'b1;
    end else if (ai && m_vld) begin
      m_vld = 1'b0;
    end
    e.q   = m_q;
    e.qn  = !m_q && !m_forbid;
    e.ill = m_forbid;
    e.cnt = m_cnt[CNT_W-1:0];
    e.vld = m_vld;
    exp_q.push_back(e);
  endtask

  // Called at a falling edge: drive inputs, predict the result of the next rising edge.
  task automatic cyc(input logic si, input logic ri, input logic ai);
    s = si; r = ri; cnt_ack = ai;
    model_step(si, ri, ai);
    @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    checks++;
    if (q !== 1'b0 || qn !== 1'b1 || illegal !== 1'b0 || set_cnt !== '0 || cnt_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s got q=%b qn=%b ill=%b cnt=%0d vld=%b exp q=0 qn=1 ill=0 cnt=0 vld=0",
               tag, q, qn, illegal, set_cnt, cnt_valid);
    end
  endtask

  task automatic monitor_loop();
    exp_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {q, qn, illegal, set_cnt, cnt_valid};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL scoreboard t=%0t got q=%b qn=%b ill=%b cnt=%0d vld=%b exp q=%b qn=%b ill=%b cnt=%0d vld=%b",
                   $time, a.q, a.qn, a.ill, a.cnt, a.vld, e.q, e.qn, e.ill, e.cnt, e.vld);
        end
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; s = 1'b0; r = 1'b0; cnt_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset_hold");
    rst_n = 1'b1;
    model_reset();
  endtask

  // Drop rst_n between edges and check the outputs before the next edge arrives.
  task automatic async_reset(input string tag);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset(tag);
    s = 1'b0; r = 1'b0; cnt_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic set_reset_pair(input logic ack);
    cyc(1'b1, 1'b0, 1'b0); cyc(1'b1, 1'b0, 1'b0);
    repeat (D) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0); cyc(1'b0, 1'b1, 1'b0);
    repeat (D) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, ack);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int sel, hold;
    logic rs, rr;
    model_reset();
    fork
      monitor_loop();
    join_none

    do_reset();
    repeat (10) cyc(1'b0, 1'b0, 1'b0);

    set_reset_pair(1'b1);

    repeat (3) cyc(1'b1, 1'b1, 1'b0);
    repeat (D + 2) cyc(1'b0, 1'b0, 1'b0);
    set_reset_pair(1'b1);

    do_reset();
    repeat (5) set_reset_pair(1'b1);

    do_reset();
    set_reset_pair(1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    repeat (D - 1) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);

    repeat (D + 2) cyc(1'b1, 1'b1, 1'b0);
    async_reset("async_forbid");
    repeat (3) cyc(1'b0, 1'b0, 1'b0);

    repeat (3) set_reset_pair(1'b0);
    async_reset("async_saturated");
    set_reset_pair(1'b0);

    repeat (400) begin
      sel  = $urandom_range(0, 9);
      hold = $urandom_range(1, 3);
      rs   = (sel <= 2) || (sel == 6);
      rr   = (sel >= 3 && sel <= 6);
      repeat (hold) cyc(rs, rr, ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
      if ($urandom_range(0, 99) == 0) async_reset("async_random");
    end

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
